// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   STATE_W          - width of the sequencer state / debug state port
//   DRAIN_CYCLES_DEF - default EX->MEM->WB drain length after a halt
//   state_e          - sequencer states (RUN, MEM_WAIT, HALT_DRAIN, HALTED)
package pipe_ctrl_pkg;

  localparam int STATE_W          = 3;
  localparam int DRAIN_CYCLES_DEF = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN        = 3'd0,
    MEM_WAIT   = 3'd1,
    HALT_DRAIN = 3'd2,
    HALTED     = 3'd3
  } state_e;

endpackage

// File: rtl/haz_detect.sv
// haz_detect: combinational load-use hazard detector.
// Ports:
//   p0_addr, p1_addr : source register addresses of the ID instruction
//   re0, re1         : source read enables
//   wr_addr          : destination register of the EX instruction
//   mem_read         : EX instruction is a load
//   hazard           : ID consumes the result of the load currently in EX
module haz_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] p0_addr,
  input  logic [REG_ADDR_W-1:0] p1_addr,
  input  logic                  re0,
  input  logic                  re1,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic                  mem_read,
  output logic                  hazard
);

  logic match0;
  logic match1;

  always_comb begin
    match0 = re0 && (p0_addr == wr_addr);
    match1 = re1 && (p1_addr == wr_addr);
    // Register 0 is hardwired, so a load "into" it never creates a dependency.
    hazard = mem_read && (wr_addr != '0) && (match0 || match1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer for the 5-stage pipeline.
// Arbitrates data-memory wait, branch mispredict, halt drain and load-use
// hazards into stall / flush / bubble controls for the pipe registers and PC.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ID_p0_addr, ID_p1_addr          : ID source register addresses
//   ID_cntrl_re0, ID_cntrl_re1      : ID source read enables
//   EX_reg_write_addr               : EX destination register
//   EX_cntrl_mem_read               : EX holds a load
//   EX_branch_mispredict            : EX branch resolved wrong
//   EX_hlt                          : EX holds a halt
//   dmem_req, dmem_ready            : MEM access pending / completing
//   pc_hold                         : PC keeps its value
//   stall_if_id/id_ex/ex_mem        : hold the named pipe register
//   flush_if_id/id_ex               : zero the named pipe register
//   insert_nop                      : bubble into ID/EX
//   halted                          : core drained, sticky until reset
//   state                           : current sequencer state (debug)
// Optional build macro HAZ_PERF_CNT_EN adds saturating event counters
//   stall_cycles, flush_events, bubble_events.
// Outputs are a combinational (Mealy) decode of state and inputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_p0_addr,
  input  logic [REG_ADDR_W-1:0] ID_p1_addr,
  input  logic                  ID_cntrl_re0,
  input  logic                  ID_cntrl_re1,
  input  logic [REG_ADDR_W-1:0] EX_reg_write_addr,
  input  logic                  EX_cntrl_mem_read,
  input  logic                  EX_branch_mispredict,
  input  logic                  EX_hlt,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_hold,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  stall_ex_mem,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  insert_nop,
  output logic                  halted,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events,
  output logic [15:0]           bubble_events,
`endif
  output logic [STATE_W-1:0]    state
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e           state_q;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             halt_set;
  logic             run_path;
  logic             load_use;
  logic             mem_wait;

  haz_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_haz_detect (
    .p0_addr (ID_p0_addr),
    .p1_addr (ID_p1_addr),
    .re0     (ID_cntrl_re0),
    .re1     (ID_cntrl_re1),
    .wr_addr (EX_reg_write_addr),
    .mem_read(EX_cntrl_mem_read),
    .hazard  (load_use)
  );

  assign mem_wait = dmem_req && !dmem_ready;
  assign state    = state_q;

  always_comb begin
    pc_hold      = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    insert_nop   = 1'b0;
    state_nxt    = state_q;
    cnt_nxt      = cnt;
    halt_set     = 1'b0;
    run_path     = 1'b0;

    case (state_q)
      RUN: run_path = 1'b1;

      // The ready cycle falls through to the RUN arbitration so that an
      // event deferred by the wait (e.g. a held mispredict) is acted on now.
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_hold      = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
        end else begin
          run_path = 1'b1;
        end
      end

      HALT_DRAIN: begin
        pc_hold     = 1'b1;
        flush_if_id = 1'b1;
        if (mem_wait) begin
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
        end else if (cnt <= CNT_W'(1)) begin
          // Final decrement reaches zero: the halt has left WB.
          cnt_nxt   = '0;
          state_nxt = HALTED;
          halt_set  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      HALTED: begin
        pc_hold      = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end

      default: state_nxt = RUN;
    endcase

    if (run_path) begin
      if (mem_wait) begin
        pc_hold      = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        state_nxt    = MEM_WAIT;
      end else if (EX_branch_mispredict) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_nxt   = RUN;
      end else if (EX_hlt) begin
        pc_hold     = 1'b1;
        flush_if_id = 1'b1;
        cnt_nxt     = CNT_W'(DRAIN_CYCLES);
        state_nxt   = HALT_DRAIN;
      end else if (load_use) begin
        pc_hold     = 1'b1;
        stall_if_id = 1'b1;
        insert_nop  = 1'b1;
        state_nxt   = RUN;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt     <= '0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt     <= cnt_nxt;
      if (halt_set) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      flush_events  <= '0;
      bubble_events <= '0;
    end else begin
      if (stall_id_ex && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (flush_id_ex && (flush_events != '1)) begin
        flush_events <= flush_events + 16'd1;
      end
      if (insert_nop && (bubble_events != '1)) begin
        bubble_events <= bubble_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (default build, DRAIN_CYCLES=2).
// Expected outputs are queued when each cycle's stimulus is applied and
// popped at the following falling edge, when the Mealy outputs have settled.
// Output vector order: {pc_hold, stall_if_id, stall_id_ex, stall_ex_mem,
//                       flush_if_id, flush_id_ex, insert_nop, halted}
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ID_p0_addr, ID_p1_addr, EX_reg_write_addr;
  logic       ID_cntrl_re0, ID_cntrl_re1, EX_cntrl_mem_read;
  logic       EX_branch_mispredict, EX_hlt, dmem_req, dmem_ready;
  logic       pc_hold, stall_if_id, stall_id_ex, stall_ex_mem;
  logic       flush_if_id, flush_id_ex, insert_nop, halted;
  logic [2:0] state;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (4),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ID_p0_addr          (ID_p0_addr),
    .ID_p1_addr          (ID_p1_addr),
    .ID_cntrl_re0        (ID_cntrl_re0),
    .ID_cntrl_re1        (ID_cntrl_re1),
    .EX_reg_write_addr   (EX_reg_write_addr),
    .EX_cntrl_mem_read   (EX_cntrl_mem_read),
    .EX_branch_mispredict(EX_branch_mispredict),
    .EX_hlt              (EX_hlt),
    .dmem_req            (dmem_req),
    .dmem_ready          (dmem_ready),
    .pc_hold             (pc_hold),
    .stall_if_id         (stall_if_id),
    .stall_id_ex         (stall_id_ex),
    .stall_ex_mem        (stall_ex_mem),
    .flush_if_id         (flush_if_id),
    .flush_id_ex         (flush_id_ex),
    .insert_nop          (insert_nop),
    .halted              (halted),
    .state               (state)
  );

  typedef struct packed {
    logic [3:0] p0;
    logic [3:0] p1;
    logic       re0;
    logic       re1;
    logic [3:0] wa;
    logic       mr;
    logic       mp;
    logic       hlt;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct {
    logic [7:0] o;
    logic [2:0] s;
  } exp_t;

  localparam logic [7:0] O_ZERO   = 8'b0000_0000;
  localparam logic [7:0] O_MEMW   = 8'b1111_0000;
  localparam logic [7:0] O_FLUSH  = 8'b0000_1100;
  localparam logic [7:0] O_HLT    = 8'b1000_1000;
  localparam logic [7:0] O_LU     = 8'b1100_0010;
  localparam logic [7:0] O_HDMEM  = 8'b1111_1000;
  localparam logic [7:0] O_HALTED = 8'b1111_0001;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic stim_t mk(input logic [3:0] p0, input logic [3:0] p1,
                               input logic re0, input logic re1,
                               input logic [3:0] wa, input logic mr,
                               input logic mp, input logic hlt,
                               input logic req, input logic rdy);
    stim_t s;
    s = '{p0: p0, p1: p1, re0: re0, re1: re1, wa: wa, mr: mr,
          mp: mp, hlt: hlt, req: req, rdy: rdy};
    return s;
  endfunction

  function automatic logic [7:0] obs();
    return {pc_hold, stall_if_id, stall_id_ex, stall_ex_mem,
            flush_if_id, flush_id_ex, insert_nop, halted};
  endfunction

  task automatic apply(input stim_t s);
    ID_p0_addr           = s.p0;
    ID_p1_addr           = s.p1;
    ID_cntrl_re0         = s.re0;
    ID_cntrl_re1         = s.re1;
    EX_reg_write_addr    = s.wa;
    EX_cntrl_mem_read    = s.mr;
    EX_branch_mispredict = s.mp;
    EX_hlt               = s.hlt;
    dmem_req             = s.req;
    dmem_ready           = s.rdy;
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic step(input stim_t s, input logic [7:0] eo, input logic [2:0] es);
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back('{o: eo, s: es});
  endtask

  task automatic test_reset();
    exp_t e;
    apply('0);
    rst_n = 1'b0;
    #2;
    exp_q.push_back('{o: O_ZERO, s: 3'd0});
    e = exp_q.pop_front();
    n_checks++;
    if ({obs(), state} !== {e.o, e.s}) begin
      n_fail++;
      $display("FAIL reset: got outs=%b state=%0d, expected outs=%b state=%0d",
               obs(), state, e.o, e.s);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t      st[7];
    logic [7:0] eo[7];
    logic [2:0] es[7];
    exp_t       e;
    st[0] = mk(4'd3, 4'd0, 1, 0, 4'd3, 1, 0, 0, 0, 0); eo[0] = O_LU;
    st[1] = mk(4'd3, 4'd0, 1, 0, 4'd0, 0, 0, 0, 0, 0); eo[1] = O_ZERO;
    st[2] = mk(4'd0, 4'd0, 1, 0, 4'd0, 1, 0, 0, 0, 0); eo[2] = O_ZERO;
    st[3] = mk(4'd0, 4'd5, 0, 1, 4'd5, 1, 0, 0, 0, 0); eo[3] = O_LU;
    st[4] = mk(4'd5, 4'd0, 0, 0, 4'd5, 1, 0, 0, 0, 0); eo[4] = O_ZERO;
    st[5] = mk(4'd3, 4'd0, 1, 0, 4'd3, 0, 0, 0, 0, 0); eo[5] = O_ZERO;
    st[6] = '0;                                        eo[6] = O_ZERO;
    for (int i = 0; i < 7; i++) begin
      es[i] = 3'd0;
      step(st[i], eo[i], es[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({obs(), state} !== {e.o, e.s}) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got outs=%b state=%0d, expected outs=%b state=%0d",
                 i, obs(), state, e.o, e.s);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t      st[6];
    logic [7:0] eo[6];
    logic [2:0] es[6];
    exp_t       e;
    for (int i = 0; i < 4; i++) begin
      st[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      eo[i] = O_MEMW;
      es[i] = (i == 0) ? 3'd0 : 3'd1;
    end
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); eo[4] = O_ZERO; es[4] = 3'd1;
    st[5] = '0;                               eo[5] = O_ZERO; es[5] = 3'd0;
    for (int i = 0; i < 6; i++) begin
      step(st[i], eo[i], es[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({obs(), state} !== {e.o, e.s}) begin
        n_fail++;
        $display("FAIL mem_wait[%0d]: got outs=%b state=%0d, expected outs=%b state=%0d",
                 i, obs(), state, e.o, e.s);
      end
    end
  endtask

  task automatic test_mispredict_in_wait();
    stim_t      st[4];
    logic [7:0] eo[4];
    logic [2:0] es[4];
    exp_t       e;
    st[0] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); eo[0] = O_MEMW;  es[0] = 3'd0;
    st[1] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); eo[1] = O_MEMW;  es[1] = 3'd1;
    st[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1); eo[2] = O_FLUSH; es[2] = 3'd1;
    st[3] = '0;                               eo[3] = O_ZERO;  es[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step(st[i], eo[i], es[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({obs(), state} !== {e.o, e.s}) begin
        n_fail++;
        $display("FAIL mispredict_in_wait[%0d]: got outs=%b state=%0d, expected outs=%b state=%0d",
                 i, obs(), state, e.o, e.s);
      end
    end
  endtask

  task automatic test_priority();
    stim_t      st[6];
    logic [7:0] eo[6];
    logic [2:0] es[6];
    exp_t       e;
    st[0] = mk(4'd3, 0, 1, 0, 4'd3, 1, 1, 0, 0, 0); eo[0] = O_FLUSH; es[0] = 3'd0;
    st[1] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);       eo[1] = O_FLUSH; es[1] = 3'd0;
    st[2] = '0;                                     eo[2] = O_ZERO;  es[2] = 3'd0;
    st[3] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);       eo[3] = O_MEMW;  es[3] = 3'd0;
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);       eo[4] = O_ZERO;  es[4] = 3'd1;
    st[5] = '0;                                     eo[5] = O_ZERO;  es[5] = 3'd0;
    for (int i = 0; i < 6; i++) begin
      step(st[i], eo[i], es[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({obs(), state} !== {e.o, e.s}) begin
        n_fail++;
        $display("FAIL priority[%0d]: got outs=%b state=%0d, expected outs=%b state=%0d",
                 i, obs(), state, e.o, e.s);
      end
    end
  endtask

  // Halt without memory wait, then with one wait cycle; each ends with a reset.
  task automatic test_halt(input bit with_wait);
    stim_t      st[6];
    logic [7:0] eo[6];
    logic [2:0] es[6];
    exp_t       e;
    st[0] = mk(4'd3, 0, 1, 0, 4'd3, 1, 0, 1, 0, 0); eo[0] = O_HLT; es[0] = 3'd0;
    if (!with_wait) begin
      st[1] = mk(4'd3, 0, 1, 0, 4'd3, 1, 1, 0, 0, 0); eo[1] = O_HLT;    es[1] = 3'd2;
      st[2] = '0;                                     eo[2] = O_HLT;    es[2] = 3'd2;
      st[3] = '0;                                     eo[3] = O_HALTED; es[3] = 3'd3;
      st[4] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);       eo[4] = O_HALTED; es[4] = 3'd3;
      st[5] = '0;                                     eo[5] = O_HALTED; es[5] = 3'd3;
    end else begin
      st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);       eo[1] = O_HDMEM;  es[1] = 3'd2;
      st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);       eo[2] = O_HLT;    es[2] = 3'd2;
      st[3] = '0;                                     eo[3] = O_HLT;    es[3] = 3'd2;
      st[4] = '0;                                     eo[4] = O_HALTED; es[4] = 3'd3;
      st[5] = '0;                                     eo[5] = O_HALTED; es[5] = 3'd3;
    end
    for (int i = 0; i < 6; i++) begin
      step(st[i], eo[i], es[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({obs(), state} !== {e.o, e.s}) begin
        n_fail++;
        $display("FAIL halt(wait=%0d)[%0d]: got outs=%b state=%0d, expected outs=%b state=%0d",
                 with_wait, i, obs(), state, e.o, e.s);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{o: O_ZERO, s: 3'd0});
    e = exp_q.pop_front();
    n_checks++;
    if ({obs(), state} !== {e.o, e.s}) begin
      n_fail++;
      $display("FAIL halt_reset(wait=%0d): got outs=%b state=%0d, expected outs=%b state=%0d",
               with_wait, obs(), state, e.o, e.s);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle inside HALT_DRAIN or MEM_WAIT.
  task automatic test_reset_midflight(input bit in_drain);
    stim_t      st[4];
    logic [7:0] eo[4];
    logic [2:0] es[4];
    exp_t       e;
    if (in_drain) begin
      st[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); eo[0] = O_HLT;  es[0] = 3'd0;
      st[1] = '0;                               eo[1] = O_HLT;  es[1] = 3'd2;
    end else begin
      st[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); eo[0] = O_MEMW; es[0] = 3'd0;
      st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); eo[1] = O_MEMW; es[1] = 3'd1;
    end
    st[2] = mk(4'd7, 0, 1, 0, 4'd7, 1, 0, 0, 0, 0); eo[2] = O_LU;   es[2] = 3'd0;
    st[3] = '0;                                     eo[3] = O_ZERO; es[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step(st[i], eo[i], es[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({obs(), state} !== {e.o, e.s}) begin
        n_fail++;
        $display("FAIL reset_mid(drain=%0d)[%0d]: got outs=%b state=%0d, expected outs=%b state=%0d",
                 in_drain, i, obs(), state, e.o, e.s);
      end
      if (i == 1) begin
        #2;
        apply('0);
        rst_n = 1'b0;
        #1;
        exp_q.push_back('{o: O_ZERO, s: 3'd0});
        e = exp_q.pop_front();
        n_checks++;
        if ({obs(), state} !== {e.o, e.s}) begin
          n_fail++;
          $display("FAIL reset_mid_async(drain=%0d): got outs=%b state=%0d, expected outs=%b state=%0d",
                   in_drain, obs(), state, e.o, e.s);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_mispredict_in_wait();
    test_priority();
    test_halt(1'b0);
    test_halt(1'b1);
    test_reset_midflight(1'b1);
    test_reset_midflight(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. Generates the stall, flush and nop-insert controls consumed by the IF/ID, ID/EX and EX/MEM pipe registers and the PC. Arbitrates four competing events: data-memory wait, branch mispredict, load-use hazard and halt drain. Also reports the core's halted status.

## Interface
- REG_ADDR_W, 4, register address width
- DRAIN_CYCLES, 2, cycles after EX_hlt before halted asserts (EX→MEM→WB)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ID_p0_addr, ID_p1_addr  in  REG_ADDR_W  source register addresses in ID
- ID_cntrl_re0, ID_cntrl_re1  in  1  source read enables
- EX_reg_write_addr  in  REG_ADDR_W  destination register in EX
- EX_cntrl_mem_read  in  1  EX instruction is a load
- EX_branch_mispredict  in  1  branch resolved wrong in EX (held while EX stalled)
- EX_hlt  in  1  halt instruction occupies EX
- dmem_req  in  1  MEM stage access pending
- dmem_ready  in  1  data memory completes this cycle
- pc_hold  out  1  PC keeps value
- stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold the named pipe register
- flush_if_id, flush_id_ex  out  1  zero the named pipe register
- insert_nop  out  1  load bubble into ID/EX
- halted  out  1  core drained; sticky until reset
- state  out  3  current FSM state (debug)

## Operation
- States: RUN=0, MEM_WAIT=1, HALT_DRAIN=2, HALTED=3. Other encodings return to RUN.
- Outputs are Mealy: a combinational decode of state and inputs. Only state, the drain counter and halted are flops.
- Load-use hazard: EX_cntrl_mem_read, and (ID_cntrl_re0 with ID_p0_addr==EX_reg_write_addr, or ID_cntrl_re1 with ID_p1_addr==EX_reg_write_addr). A match on address 0 is never a hazard.
- Priority in RUN, highest first:
  - mem wait (dmem_req & ~dmem_ready): all three stall_* and pc_hold high; next MEM_WAIT.
  - mispredict: flush_if_id and flush_id_ex high, no stalls; stay RUN.
  - EX_hlt: pc_hold and flush_if_id high; load counter with DRAIN_CYCLES; next HALT_DRAIN.
  - load-use: pc_hold, stall_if_id and insert_nop high; stay RUN.
  - otherwise all outputs 0.
- MEM_WAIT: all stalls and pc_hold stay high while ~dmem_ready.
  - On the dmem_ready cycle, the outputs evaluate exactly as RUN (minus the mem term) and the FSM follows the RUN transition. A mispredict deferred by the stall is therefore handled on the exit cycle.
- HALT_DRAIN: pc_hold and flush_if_id high every cycle. Mispredict and load-use are ignored.
  - mem wait additionally asserts all stalls and freezes the counter.
  - Otherwise the counter decrements. When it is 0, next state is HALTED and halted is set.
- HALTED: pc_hold, stall_if_id, stall_id_ex and stall_ex_mem high; halted=1. No exit except reset.

## Timing
- Reset: state=RUN, counter=0, halted=0. Every output is 0 while in reset with inputs idle.
- Control latency is 0: outputs respond in the same cycle as the inputs. State changes on the next clk.
- Load-use costs exactly 1 bubble; the hazard clears next cycle because EX holds a nop.
- Halt: halted rises DRAIN_CYCLES+1 clocks after the first EX_hlt cycle, plus any mem-wait cycles.
- rst_n asserted mid-MEM_WAIT or mid-HALT_DRAIN returns to RUN immediately and asynchronously.

## Configuration
- HAZ_PERF_CNT_EN defined adds three output ports: stall_cycles [15:0], flush_events [15:0] and bubble_events [15:0]. All are saturating counters reset to 0.
  - stall_cycles increments on any stall_id_ex cycle.
  - flush_events increments on any flush_id_ex cycle.
  - bubble_events increments on any insert_nop cycle.
- HAZ_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package pipe_ctrl_pkg holds the state enum (RUN/MEM_WAIT/HALT_DRAIN/HALTED), the state width and the DRAIN_CYCLES default.
- Sub-module haz_detect is purely combinational and produces the load-use hazard flag. pipe_hazard_ctrl contains the FSM, counter and output decode.

## Test plan
- Load r3, then ADD r3 consumer (re0, p0=3): exactly one cycle of pc_hold=stall_if_id=insert_nop=1, then all 0. Repeat with p0=0: no bubble.
- dmem_req=1, dmem_ready low for 4 cycles: all stalls and pc_hold high for 4 cycles, state=1; 0 on the ready cycle.
- Mispredict asserted during a 2-cycle mem wait: no flush while waiting; flush_if_id=flush_id_ex=1 on the dmem_ready cycle only.
- Mispredict and load-use in the same cycle: flushes high, insert_nop=0.
- EX_hlt with DRAIN_CYCLES=2: halted=1 on the 3rd clock; with one mem-wait cycle inserted, on the 4th. Stays set until rst_n.
- rst_n pulsed low in HALT_DRAIN: state=0 and halted=0 immediately; normal RUN afterwards.
